// File: rtl/rx_msg_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_msg_buffer_if
// Brief    : Write, header/commit and reader signal bundle of rx_msg_buffer.
// Revision : 1.0
// ============================================================================
interface rx_msg_buffer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              wr_req;
    logic              wr_rdy;
    logic [15:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              hdr_en;
    logic [7:0]        rx_flag;
    logic [15:0]       rx_len;
    logic              end_msg;
    logic              msg_right;
    logic              msg_line;
    logic              msg_valid;
    logic [7:0]        msg_flag;
    logic [15:0]       msg_len;
    logic              msg_src;
    logic              msg_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        status;
    logic [7:0]        bad_cnt;

    modport master (
        output wr_req, wr_addr, wr_data, hdr_en, rx_flag, rx_len,
               end_msg, msg_right, msg_line, msg_ack, rd_addr,
        input  wr_rdy, msg_valid, msg_flag, msg_len, msg_src,
               rd_data, status, bad_cnt
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, hdr_en, rx_flag, rx_len,
               end_msg, msg_right, msg_line, msg_ack, rd_addr,
        output wr_rdy, msg_valid, msg_flag, msg_len, msg_src,
               rd_data, status, bad_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rx_msg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_msg_buffer
// Brief    : Receive-path RAM responder with message descriptor commit.
// Revision : 1.0
// ============================================================================
module rx_msg_buffer #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int WR_WAIT = 1
) (
    input  logic           clk,
    input  logic           rst_l,
    rx_msg_buffer_if.slave bus
);
    localparam int unsigned c_depth     = 32'd1 << ADDR_W;
    localparam logic [3:0]  c_wait_last = (WR_WAIT > 0) ? 4'(WR_WAIT - 1) : 4'd0;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_write = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_ack   = 3'd3;
    localparam logic [2:0] c_st_hold  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [15:0]       r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [3:0]        r_wait_cnt;
    logic              r_wr_rdy;
    logic              w_addr_ok;

    logic [DATA_W-1:0] r_mem [0:c_depth-1];
    logic [DATA_W-1:0] r_rd_data;

    logic [7:0]  r_hdr_flag;
    logic [15:0] r_hdr_len;
    logic        r_end_pend;
    logic        r_pend_right;
    logic        r_pend_line;
    logic        r_msg_valid;
    logic [7:0]  r_msg_flag;
    logic [15:0] r_msg_len;
    logic        r_msg_src;
    logic [2:0]  r_status;
    logic [2:0]  w_status_nxt;
    logic [7:0]  r_bad_cnt;
    logic        w_ev;
    logic        w_ev_right;
    logic        w_ev_line;
    logic        w_commit;
    logic        w_good;
    logic        w_bad;

    assign w_addr_ok = ({16'd0, r_wr_addr} < c_depth);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (bus.wr_req) w_state_nxt = c_st_write;
            c_st_write: w_state_nxt = (WR_WAIT == 0) ? c_st_ack : c_st_wait;
            c_st_wait:  if (r_wait_cnt == c_wait_last) w_state_nxt = c_st_ack;
            c_st_ack:   w_state_nxt = c_st_hold;
            c_st_hold:  if (!bus.wr_req) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wait_cnt <= '0;
            r_wr_rdy   <= 1'b0;
        end else begin
            if (r_state == c_st_idle && bus.wr_req) begin
                r_wr_addr <= bus.wr_addr;
                r_wr_data <= bus.wr_data;
            end
            r_wait_cnt <= (r_state == c_st_wait) ? r_wait_cnt + 4'd1 : 4'd0;
            r_wr_rdy   <= (w_state_nxt == c_st_ack);
        end
    end

    // Out-of-range writes are dropped rather than aliased into the RAM.
    always_ff @(posedge clk) begin
        if (r_state == c_st_write && w_addr_ok)
            r_mem[r_wr_addr[ADDR_W-1:0]] <= r_wr_data;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) r_rd_data <= '0;
        else        r_rd_data <= r_mem[bus.rd_addr];
    end

    // A same-cycle end_msg takes effect immediately when the writer is idle.
    assign w_ev       = bus.end_msg | r_end_pend;
    assign w_ev_right = bus.end_msg ? bus.msg_right : r_pend_right;
    assign w_ev_line  = bus.end_msg ? bus.msg_line  : r_pend_line;
    assign w_commit   = w_ev && (r_state == c_st_idle);
    assign w_good     = w_commit & w_ev_right;
    assign w_bad      = w_commit & ~w_ev_right;

    always_comb begin
        w_status_nxt = bus.msg_ack ? 3'b000 : r_status;
        if (r_state == c_st_write && !w_addr_ok)
            w_status_nxt[0] = 1'b1;
        if (w_good && r_msg_valid && !bus.msg_ack)
            w_status_nxt[1] = 1'b1;
        if (bus.hdr_en && ({16'd0, bus.rx_len} > c_depth))
            w_status_nxt[2] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_hdr_flag   <= '0;
            r_hdr_len    <= '0;
            r_end_pend   <= 1'b0;
            r_pend_right <= 1'b0;
            r_pend_line  <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_msg_flag   <= '0;
            r_msg_len    <= '0;
            r_msg_src    <= 1'b0;
            r_status     <= '0;
            r_bad_cnt    <= '0;
        end else begin
            if (bus.hdr_en) begin
                r_hdr_flag <= bus.rx_flag;
                r_hdr_len  <= bus.rx_len;
            end
            if (w_commit) begin
                r_end_pend <= 1'b0;
            end else if (bus.end_msg) begin
                r_end_pend   <= 1'b1;
                r_pend_right <= bus.msg_right;
                r_pend_line  <= bus.msg_line;
            end
            if (w_good) begin
                r_msg_valid <= 1'b1;
                r_msg_flag  <= r_hdr_flag;
                r_msg_len   <= r_hdr_len;
                r_msg_src   <= w_ev_line;
            end else if (bus.msg_ack) begin
                r_msg_valid <= 1'b0;
            end
            if (w_bad && r_bad_cnt != 8'hFF)
                r_bad_cnt <= r_bad_cnt + 8'd1;
            r_status <= w_status_nxt;
        end
    end

    assign bus.wr_rdy    = r_wr_rdy;
    assign bus.rd_data   = r_rd_data;
    assign bus.msg_valid = r_msg_valid;
    assign bus.msg_flag  = r_msg_flag;
    assign bus.msg_len   = r_msg_len;
    assign bus.msg_src   = r_msg_src;
    assign bus.status    = r_status;
    assign bus.bad_cnt   = r_bad_cnt;
endmodule
`default_nettype wire

// File: tb/tb_rx_msg_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_msg_buffer
// Brief    : Scoreboard bench for rx_msg_buffer against a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_rx_msg_buffer;
    localparam int ADDR_W    = 4;
    localparam int DATA_W    = 8;
    localparam int WR_WAIT   = 1;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int WR_LAT    = 2 + WR_WAIT;
    localparam int KIND_DESC = 0;
    localparam int KIND_RD   = 1;
    localparam int KIND_ALL  = 2;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    rx_msg_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rx_msg_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_WAIT(WR_WAIT)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    typedef struct {
        int          kind;
        int          due;
        logic        valid;
        logic [7:0]  flag;
        logic [15:0] len;
        logic        src;
        logic [2:0]  status;
        logic [7:0]  bad;
        logic [7:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   wr_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: message descriptor state and RAM image
    logic [7:0]  ref_mem [DEPTH];
    bit          known   [DEPTH];
    logic        m_valid;
    logic [7:0]  m_flag;
    logic [15:0] m_len;
    logic        m_src;
    logic [2:0]  m_status;
    logic [7:0]  m_bad;
    logic [7:0]  h_flag;
    logic [15:0] h_len;

    function void model_reset();
        m_valid = 1'b0; m_flag = '0; m_len = '0; m_src = 1'b0;
        m_status = '0; m_bad = '0; h_flag = '0; h_len = '0;
    endfunction

    function void model_commit(bit right, bit line, bit ack);
        if (ack) m_status = 3'b000;
        if (right) begin
            if (m_valid && !ack) m_status[1] = 1'b1;
            m_valid = 1'b1;
            m_flag  = h_flag;
            m_len   = h_len;
            m_src   = line;
        end else begin
            if (m_bad != 8'hFF) m_bad = m_bad + 8'd1;
            if (ack) m_valid = 1'b0;
        end
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic compare(exp_t e);
        if (e.kind == KIND_RD) begin
            check("rd_data", 32'(bus.rd_data), 32'(e.rd));
        end else begin
            check("msg_valid", 32'(bus.msg_valid), 32'(e.valid));
            check("msg_flag",  32'(bus.msg_flag),  32'(e.flag));
            check("msg_len",   32'(bus.msg_len),   32'(e.len));
            check("msg_src",   32'(bus.msg_src),   32'(e.src));
            check("status",    32'(bus.status),    32'(e.status));
            check("bad_cnt",   32'(bus.bad_cnt),   32'(e.bad));
            if (e.kind == KIND_ALL) begin
                check("rd_data_reset", 32'(bus.rd_data), 32'(e.rd));
                check("wr_rdy_reset",  32'(bus.wr_rdy),  32'd0);
            end
        end
    endtask

    // Monitor: latency of every wr_rdy pulse, and any snapshot due this cycle
    initial begin : monitor
        logic req_prev;
        int   start;
        req_prev = 1'b0;
        start    = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.wr_req && !req_prev) start = cyc - 1;
            req_prev = bus.wr_req;
            if (bus.wr_rdy) begin
                if (wr_q.size() == 0) begin
                    check("wr_rdy_unexpected", 32'd1, 32'd0);
                end else begin
                    int lat;
                    lat = wr_q.pop_front();
                    check("wr_latency", 32'(cyc - start), 32'(lat));
                end
            end
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].due == cyc) begin
                    compare(exp_q[i]);
                    exp_q.delete(i);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic push_desc(int kind, int off);
        exp_t e;
        e.kind = kind; e.due = cyc + off; e.valid = m_valid; e.flag = m_flag;
        e.len = m_len; e.src = m_src; e.status = m_status; e.bad = m_bad; e.rd = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic do_write(logic [15:0] addr, logic [7:0] data, int hold);
        bit got;
        bus.wr_req = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        wr_q.push_back(WR_LAT);
        if (int'(addr) < DEPTH) begin
            ref_mem[addr[ADDR_W-1:0]] = data;
            known[addr[ADDR_W-1:0]]   = 1'b1;
        end else begin
            m_status[0] = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = bus.wr_rdy;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL wr_rdy_timeout: no wr_rdy within 20 cycles, expected after %0d", WR_LAT);
        end
        repeat (hold) @(negedge clk);
        bus.wr_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_hdr(logic [7:0] flag, logic [15:0] len);
        bus.hdr_en = 1'b1; bus.rx_flag = flag; bus.rx_len = len;
        h_flag = flag; h_len = len;
        if (int'(len) > DEPTH) m_status[2] = 1'b1;
        push_desc(KIND_DESC, 1);
        @(negedge clk);
        bus.hdr_en = 1'b0;
    endtask

    task automatic do_end(bit right, bit line, bit ack);
        bus.end_msg = 1'b1; bus.msg_right = right; bus.msg_line = line; bus.msg_ack = ack;
        model_commit(right, line, ack);
        push_desc(KIND_DESC, 1);
        @(negedge clk);
        bus.end_msg = 1'b0; bus.msg_ack = 1'b0;
    endtask

    task automatic do_ack();
        bus.msg_ack = 1'b1;
        m_valid = 1'b0; m_status = 3'b000;
        push_desc(KIND_DESC, 1);
        @(negedge clk);
        bus.msg_ack = 1'b0;
    endtask

    task automatic do_read(int addr);
        exp_t e;
        bus.rd_addr = ADDR_W'(addr);
        e.kind = KIND_RD; e.due = cyc + 1; e.rd = ref_mem[addr];
        e.valid = 1'b0; e.flag = '0; e.len = '0; e.src = 1'b0; e.status = '0; e.bad = '0;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin : stimulus
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.hdr_en = 1'b0; bus.rx_flag = '0; bus.rx_len = '0;
        bus.end_msg = 1'b0; bus.msg_right = 1'b0; bus.msg_line = 1'b0;
        bus.msg_ack = 1'b0; bus.rd_addr = '0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0; ref_mem[i] = 8'h00;
        end

        repeat (2) @(negedge clk);
        push_desc(KIND_ALL, 1);
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        // Single write, long hold, read back
        do_write(16'd5, 8'h3C, 4);
        do_read(5);

        // Complete message
        do_hdr(8'hA5, 16'd4);
        for (int i = 0; i < 4; i++) do_write(16'(i), 8'($urandom), int'($urandom_range(0, 2)));
        do_end(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_read(i);

        // Second message without ack: overrun
        do_hdr(8'h11, 16'd2);
        do_end(1'b1, 1'b0, 1'b0);
        do_ack();

        // Bad messages, then saturation
        repeat (3)   do_end(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        repeat (297) do_end(1'b0, 1'($urandom_range(0, 1)), 1'b0);

        // Out-of-range address and length
        do_write(16'(DEPTH), 8'hEE, 1);
        do_read(0);
        do_hdr(8'h22, 16'(DEPTH + 1));
        do_ack();

        // Commit and ack in the same cycle
        do_hdr(8'h33, 16'd3);
        do_end(1'b1, 1'b0, 1'b0);
        do_hdr(8'h44, 16'(DEPTH + 2));
        do_end(1'b1, 1'b1, 1'b1);
        do_ack();

        // end_msg while the writer waits; later event replaces the first
        do_hdr(8'h66, 16'd5);
        bus.wr_req = 1'b1; bus.wr_addr = 16'd7; bus.wr_data = 8'h5A;
        wr_q.push_back(WR_LAT);
        ref_mem[7] = 8'h5A; known[7] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.end_msg = 1'b1; bus.msg_right = 1'b0; bus.msg_line = 1'b0;
        @(negedge clk);
        bus.msg_right = 1'b1; bus.msg_line = 1'b1;
        @(negedge clk);
        bus.end_msg = 1'b0;
        push_desc(KIND_DESC, 2);
        @(negedge clk);
        bus.wr_req = 1'b0;
        model_commit(1'b1, 1'b1, 1'b0);
        push_desc(KIND_DESC, 2);
        repeat (2) @(negedge clk);
        do_read(7);

        // Reset during WAIT with a commit pending
        do_hdr(8'h77, 16'd6);
        bus.wr_req = 1'b1; bus.wr_addr = 16'd9; bus.wr_data = 8'hC3;
        ref_mem[9] = 8'hC3; known[9] = 1'b1;
        @(negedge clk);
        bus.end_msg = 1'b1; bus.msg_right = 1'b1; bus.msg_line = 1'b1;
        @(negedge clk);
        bus.end_msg = 1'b0; bus.wr_req = 1'b0; rst_l = 1'b0;
        model_reset();
        push_desc(KIND_ALL, 1);
        @(negedge clk);
        rst_l = 1'b1;
        push_desc(KIND_DESC, 3);
        @(negedge clk);
        do_read(9);
        repeat (2) @(negedge clk);

        // Randomized traffic
        do_hdr(8'h5C, 16'd3);
        for (int n = 0; n < 80; n++) begin
            int op;
            int ra;
            op = int'($urandom_range(0, 5));
            case (op)
                0, 1: begin
                    if ($urandom_range(0, 9) == 0)
                        do_write(16'(DEPTH + int'($urandom_range(0, 3))), 8'($urandom), int'($urandom_range(0, 3)));
                    else
                        do_write(16'($urandom_range(0, DEPTH - 1)), 8'($urandom), int'($urandom_range(0, 3)));
                end
                2: do_hdr(8'($urandom), 16'($urandom_range(0, DEPTH + 2)));
                3: do_end(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
                4: do_ack();
                default: begin
                    ra = int'($urandom_range(0, DEPTH - 1));
                    if (known[ra]) do_read(ra);
                end
            endcase
        end

        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: %0d snapshots and %0d write acks outstanding, expected 0 and 0",
                     exp_q.size(), wr_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
